// File: rtl/spi_input_frontend.sv
// Three-channel SPI pin conditioner: two-flop synchronizer, debounce filter and
// edge pulses for SCLK, CS and MOSI, all in the clk domain.
module spi_input_frontend #(
    parameter int counterwidth = 3,
    parameter int waittime     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_conditioned,
    output logic sclk_posedge,
    output logic sclk_negedge,
    output logic cs_conditioned,
    output logic cs_falling,
    output logic cs_rising,
    output logic mosi_conditioned
);

    // Channel index: 0 = SCLK, 1 = CS, 2 = MOSI. CS idles high (deselected).
    localparam logic [2:0] idleLevel = 3'b010;
    localparam logic [counterwidth-1:0] waitCount = counterwidth'(waittime);
    localparam logic [counterwidth-1:0] countStep = counterwidth'(1);

    logic [2:0] pinRaw;
    logic [2:0] sync0;
    logic [2:0] sync1;
    logic [2:0] level;
    logic [2:0] accept;
    logic [counterwidth-1:0] count [3];
    // MOSI has no pulse outputs, so only SCLK and CS carry pulse registers.
    logic [1:0] riseQ;
    logic [1:0] fallQ;

    assign pinRaw = {mosi_pin, cs_pin, sclk_pin};

    always_comb begin
        accept = '0;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (sync1[i] != level[i]) && (count[i] == waitCount);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= idleLevel;
            sync1 <= idleLevel;
            level <= idleLevel;
            for (int i = 0; i < 3; i++) begin
                count[i] <= '0;
            end
            riseQ <= '0;
            fallQ <= '0;
        end else begin
            sync0 <= pinRaw;
            sync1 <= sync0;
            riseQ <= accept[1:0] & sync1[1:0];
            fallQ <= accept[1:0] & ~sync1[1:0];
            for (int i = 0; i < 3; i++) begin
                // Any sample matching the current level restarts the run.
                if (sync1[i] == level[i]) begin
                    count[i] <= '0;
                end else if (!accept[i]) begin
                    count[i] <= count[i] + countStep;
                end else begin
                    level[i] <= sync1[i];
                    count[i] <= '0;
                end
            end
        end
    end

    assign sclk_conditioned = level[0];
    assign sclk_posedge     = riseQ[0];
    assign sclk_negedge     = fallQ[0];
    assign cs_conditioned   = level[1];
    assign cs_falling       = fallQ[1];
    assign cs_rising        = riseQ[1];
    assign mosi_conditioned = level[2];

endmodule
